// File: rtl/fibl_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fibl_rr_sched_if
// Purpose  : Bundles the requester-side and server-side handshake signals of
//            the fibl round-robin scheduler.
// Modports : slave  - scheduler view (drives grants, responses, server request)
//            master - environment view (requesters and the fibl server)
// Signals  : req_valid/req_arg/req_ready         requester request channel
//            resp_valid/resp_data/resp_err/resp_ready  response channel
//            srv_in_valid/srv_in_ready/srv_in0    server argument channel
//            srv_out_valid/srv_out_ready/srv_out0 server result channel
//            busy                                 scheduler not idle
//            cache_hit                            only with FIBL_SCHED_CACHE_EN
// Optional : FIBL_SCHED_CACHE_EN adds the cache_hit signal
// Revision : 1.0 - initial release
// ============================================================================
interface fibl_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_arg;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic [NREQ-1:0]   resp_ready;
  logic              srv_in_valid;
  logic              srv_in_ready;
  logic [W-1:0]      srv_in0;
  logic              srv_out_valid;
  logic              srv_out_ready;
  logic [W-1:0]      srv_out0;
  logic              busy;
`ifdef FIBL_SCHED_CACHE_EN
  logic              cache_hit;
`endif

  modport slave (
    input  req_valid, req_arg, resp_ready, srv_in_ready, srv_out_valid, srv_out0,
    output req_ready, resp_valid, resp_data, resp_err, srv_in_valid, srv_in0,
    output srv_out_ready, busy
`ifdef FIBL_SCHED_CACHE_EN
    , output cache_hit
`endif
  );

  modport master (
    output req_valid, req_arg, resp_ready, srv_in_ready, srv_out_valid, srv_out0,
    input  req_ready, resp_valid, resp_data, resp_err, srv_in_valid, srv_in0,
    input  srv_out_ready, busy
`ifdef FIBL_SCHED_CACHE_EN
    , input cache_hit
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fibl_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : fibl_rr_sched
// Purpose  : Round-robin scheduler sharing one fibl compute core among NREQ
//            requesters. One request is outstanding at a time; arguments
//            above MAX_ARG are answered with an error and never reach the core.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - fibl_rr_sched_if.slave (request, response, server channels,
//                   busy, optional cache_hit)
// Optional : FIBL_SCHED_CACHE_EN - one-entry result cache; a repeated legal
//            argument is answered from the cache without a server transaction.
// Revision : 1.0 - initial release
// ============================================================================
module fibl_rr_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int MAX_ARG = 24
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fibl_rr_sched_if.slave   bus
);

  localparam int             PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0]   c_MAX_ARG = W'(MAX_ARG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   r_owner;
  logic [W-1:0]    r_arg;
  logic [W-1:0]    r_data;
  logic            r_err;

  logic            w_found;
  logic [PW-1:0]   w_gidx;
  logic [W-1:0]    w_garg;
  logic            w_illegal;
  logic            w_grant;

  logic [NREQ-1:0] w_req_ready;
  logic [NREQ-1:0] w_resp_valid;
  logic            w_srv_in_valid;
  logic [W-1:0]    w_srv_in0;
  logic            w_srv_out_ready;
  logic            w_busy;

`ifdef FIBL_SCHED_CACHE_EN
  logic            r_cvalid;
  logic [W-1:0]    r_carg;
  logic [W-1:0]    r_cres;
  logic            w_hit;
`endif

  // (base + off) mod NREQ for offsets below NREQ
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin search starting at the pointer, first valid requester wins
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_valid[f_wrap(r_rr, k)]) begin
        w_found = 1'b1;
        w_gidx  = f_wrap(r_rr, k);
      end
    end
  end

  assign w_garg    = bus.req_arg[int'(w_gidx)*W +: W];
  assign w_illegal = (w_garg > c_MAX_ARG);
  // Gated by rst so no grant is advertised while the block is held in reset
  assign w_grant   = (r_state == S_IDLE) && w_found && !rst;

`ifdef FIBL_SCHED_CACHE_EN
  assign w_hit = !w_illegal && r_cvalid && (w_garg == r_carg);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next          = r_state;
    w_req_ready     = '0;
    w_resp_valid    = '0;
    w_srv_in_valid  = 1'b0;
    w_srv_in0       = '0;
    w_srv_out_ready = 1'b0;
    w_busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_grant) begin
          w_req_ready[w_gidx] = 1'b1;
          if (w_illegal)
            w_next = S_RESP;
`ifdef FIBL_SCHED_CACHE_EN
          else if (w_hit)
            w_next = S_RESP;
`endif
          else
            w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_srv_in_valid = 1'b1;
        w_srv_in0      = r_arg;
        if (bus.srv_in_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_srv_out_ready = 1'b1;
        if (bus.srv_out_valid) w_next = S_RESP;
      end
      S_RESP: begin
        w_resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready[r_owner]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction context: owner, argument, response payload, rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr    <= '0;
      r_owner <= '0;
      r_arg   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gidx;
        r_arg   <= w_garg;
        r_rr    <= f_wrap(w_gidx, 1);
        if (w_illegal) begin
          r_err  <= 1'b1;
          r_data <= '0;
        end
`ifdef FIBL_SCHED_CACHE_EN
        else if (w_hit) begin
          r_err  <= 1'b0;
          r_data <= r_cres;
        end
`endif
      end
      if ((r_state == S_WAIT) && bus.srv_out_valid) begin
        r_data <= bus.srv_out0;
        r_err  <= 1'b0;
      end
    end
  end

`ifdef FIBL_SCHED_CACHE_EN
  // Every server result refreshes the single cache entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cvalid <= 1'b0;
      r_carg   <= '0;
      r_cres   <= '0;
    end else if ((r_state == S_WAIT) && bus.srv_out_valid) begin
      r_cvalid <= 1'b1;
      r_carg   <= r_arg;
      r_cres   <= bus.srv_out0;
    end
  end

  assign bus.cache_hit = w_grant && w_hit;
`endif

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = w_resp_valid;
  assign bus.resp_data     = r_data;
  assign bus.resp_err      = r_err;
  assign bus.srv_in_valid  = w_srv_in_valid;
  assign bus.srv_in0       = w_srv_in0;
  assign bus.srv_out_ready = w_srv_out_ready;
  assign bus.busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fibl_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fibl_rr_sched
// Purpose  : Directed self-checking bench for fibl_rr_sched with a behavioural
//            fibl server model (programmable latency, random in_ready stalls).
// Optional : FIBL_SCHED_CACHE_EN selects the cache expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_fibl_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fibl_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  fibl_rr_sched #(.NREQ(NREQ), .W(W), .MAX_ARG(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural fibl server ----------------
  int           lat      = 0;
  bit           stall_en = 1'b0;
  int           hs_count = 0;
  logic [W-1:0] last_arg = '0;
  logic         sbusy;
  int           cnt;
  logic [W-1:0] sres;

  function automatic logic [W-1:0] fib_model(input logic [W-1:0] n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = W'(1);
    for (int i = 0; i < int'(n) && i < 40; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbusy             <= 1'b0;
      cnt               <= 0;
      sres              <= '0;
      bus.srv_in_ready  <= 1'b0;
      bus.srv_out_valid <= 1'b0;
      bus.srv_out0      <= '0;
    end else if (!sbusy) begin
      if (bus.srv_in_valid && bus.srv_in_ready) begin
        sbusy            <= 1'b1;
        cnt              <= lat;
        sres             <= fib_model(bus.srv_in0);
        last_arg         <= bus.srv_in0;
        hs_count         <= hs_count + 1;
        bus.srv_in_ready <= 1'b0;
      end else begin
        bus.srv_in_ready <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end else if (!bus.srv_out_valid) begin
      if (cnt == 0) begin
        bus.srv_out_valid <= 1'b1;
        bus.srv_out0      <= sres;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (bus.srv_out_ready) begin
      bus.srv_out_valid <= 1'b0;
      bus.srv_out0      <= '0;
      sbusy             <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {20'd0, bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err,
            bus.srv_in_valid, bus.srv_in0, bus.srv_out_ready, bus.busy};
  endfunction

  logic g_hit = 1'b0;

  // Called at a negedge; returns just after the accepting posedge
  task automatic issue_req(input int i, input logic [W-1:0] arg, output bit ok);
    ok = 1'b0;
    bus.req_arg[i*W +: W] = arg;
    bus.req_valid[i]      = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (bus.req_ready[i]) begin
        ok = 1'b1;
`ifdef FIBL_SCHED_CACHE_EN
        g_hit = bus.cache_hit;
`endif
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  // Called at a negedge; stays on a negedge
  task automatic wait_resp(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      if (bus.resp_valid != '0) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] exp3 [4];
  bit ok, got;
  int h0, ng, nr, gi;

  initial begin
    exp3[0] = 16'd1; exp3[1] = 16'd1; exp3[2] = 16'd2; exp3[3] = 16'd46368;
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_arg    = '0;
    bus.resp_ready = '1;

    // Reset: outputs quiet even with requests pending
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    #1;
    check("reset_outs_with_req", outs_vec(), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_outs", outs_vec(), 64'd0);
    end

    // Requester 2, arg 10, stalled server with latency 3
    lat = 3; stall_en = 1'b1; h0 = hs_count;
    issue_req(2, 16'd10, ok);
    check("t1_grant", 64'(ok), 64'd1);
    @(negedge clk);
    check("t1_issue_next_cycle", 64'(bus.srv_in_valid), 64'd1);
    check("t1_srv_in0", 64'(bus.srv_in0), 64'd10);
    wait_resp(100, got);
    check("t1_resp_seen", 64'(got), 64'd1);
    check("t1_resp_valid", 64'(bus.resp_valid), 64'b0100);
    check("t1_resp_data", 64'(bus.resp_data), 64'd55);
    check("t1_resp_err", 64'(bus.resp_err), 64'd0);
    check("t1_srv_count", 64'(hs_count - h0), 64'd1);
    check("t1_srv_arg", 64'(last_arg), 64'd10);
    @(negedge clk);
    check("t1_idle_after", 64'(bus.busy), 64'd0);

    // Restart pointer at 0, then all four requesters at once
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat = 1;
    bus.req_arg   = {16'd24, 16'd3, 16'd2, 16'd1};
    bus.req_valid = '1;
    ng = 0; nr = 0;
    for (int c = 0; c < 2000 && nr < 4; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        check($sformatf("t3_grant%0d", ng), 64'(bus.req_ready), 64'(1 << ng));
        gi = 0;
        for (int b = 0; b < NREQ; b++) if (bus.req_ready[b]) gi = b;
        ng++;
        @(posedge clk);
        #1;
        bus.req_valid[gi] = 1'b0;
      end else if (bus.resp_valid != '0) begin
        check($sformatf("t3_route%0d", nr), 64'(bus.resp_valid), 64'(1 << nr));
        check($sformatf("t3_data%0d", nr), 64'(bus.resp_data), 64'(exp3[nr]));
        nr++;
        @(posedge clk);
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    check("t3_all_served", 64'(nr), 64'd4);
    bus.req_valid = '0;

    // Range reject: requester 1, arg 25
    h0 = hs_count;
    issue_req(1, 16'd25, ok);
    check("t4_grant", 64'(ok), 64'd1);
    @(negedge clk);
    check("t4_resp_valid", 64'(bus.resp_valid), 64'b0010);
    check("t4_resp_err", 64'(bus.resp_err), 64'd1);
    check("t4_resp_data", 64'(bus.resp_data), 64'd0);
    check("t4_no_srv_valid", 64'(bus.srv_in_valid), 64'd0);
    @(negedge clk);
    check("t4_no_srv_hs", 64'(hs_count - h0), 64'd0);
    check("t4_idle_after", 64'(bus.busy), 64'd0);

    // Reset while waiting on arg 20
    lat = 7; stall_en = 1'b0;
    issue_req(0, 16'd20, ok);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.srv_out_ready) got = 1'b1;
    end
    check("t5_reached_wait", 64'(got), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_reset_outs", outs_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat = 2;
    issue_req(0, 16'd5, ok);
    @(negedge clk);
    wait_resp(100, got);
    check("t5_resp_valid", 64'(bus.resp_valid), 64'b0001);
    check("t5_resp_data", 64'(bus.resp_data), 64'd5);
    @(negedge clk);

    // Repeated arg 12 from requester 3
    stall_en = 1'b1; h0 = hs_count;
    issue_req(3, 16'd12, ok);
`ifdef FIBL_SCHED_CACHE_EN
    check("t6_first_no_hit", 64'(g_hit), 64'd0);
`endif
    @(negedge clk);
    wait_resp(100, got);
    check("t6_first_data", 64'(bus.resp_data), 64'd144);
    @(negedge clk);
    issue_req(3, 16'd12, ok);
    @(negedge clk);
`ifdef FIBL_SCHED_CACHE_EN
    check("t6_second_hit", 64'(g_hit), 64'd1);
    check("t6_hit_latency", 64'(bus.resp_valid), 64'b1000);
`endif
    wait_resp(100, got);
    check("t6_second_route", 64'(bus.resp_valid), 64'b1000);
    check("t6_second_data", 64'(bus.resp_data), 64'd144);
    check("t6_second_err", 64'(bus.resp_err), 64'd0);
    @(negedge clk);
`ifdef FIBL_SCHED_CACHE_EN
    check("t6_srv_count", 64'(hs_count - h0), 64'd1);
`else
    check("t6_srv_count", 64'(hs_count - h0), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fibl_rr_sched.md
Name: fibl_rr_sched

Overview:
Round-robin scheduler that shares one `tests_fibl` compute instance (sync handshake, single `intN` argument and result) among NREQ requesters.
- Accepts one request at a time, range-checks the argument and issues it to the server.
- Waits for the result and routes it back to the winning requester.
- Sits between board-level stimulus sources (switch/button sweepers, UART) and the single fibl core.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, argument/result width (matches `intN`)
MAX_ARG, 24, largest legal argument; larger arguments are rejected without using the server

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_arg  in  NREQ*W  packed arguments; requester i uses bits [i*W +: W]
req_ready  out  NREQ  one-hot; high on the cycle request i is accepted
resp_valid  out  NREQ  one-hot response valid to the owning requester
resp_data  out  W  shared response data
resp_err  out  1  response is a range rejection (resp_data = 0)
resp_ready  in  NREQ  per-requester response ready
srv_in_valid  out  1  to fibl `in_valid`
srv_in_ready  in  1  from fibl `in_ready`
srv_in0  out  W  to fibl `in0`
srv_out_valid  in  1  from fibl `out_valid`
srv_out_ready  out  1  to fibl `out_ready`
srv_out0  in  W  from fibl `out0`
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate):
  - state = IDLE, rr pointer = 0.
  - All outputs 0: req_ready, resp_valid, resp_data, resp_err, srv_in_valid, srv_in0, srv_out_ready, busy.
- IDLE:
  - Grant = first i with req_valid[i], scanning from rr pointer upward with wrap.
  - On grant, pulse req_ready[i] for exactly 1 cycle and latch the owner index and req_arg slice.
  - Set rr pointer = (i+1) mod NREQ.
  - If arg > MAX_ARG (unsigned): go to RESP with resp_err = 1, data = 0.
  - Otherwise go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - srv_in_valid = 1, srv_in0 = latched arg.
  - Leave only on srv_in_valid & srv_in_ready, then go to WAIT.
  - srv_in0 is held stable while waiting.
- WAIT:
  - srv_out_ready = 1.
  - On srv_out_valid: latch srv_out0, set resp_err = 0, go to RESP.
- RESP:
  - resp_valid[owner] = 1, other bits 0; resp_data and resp_err held stable.
  - On resp_ready[owner], go to IDLE next cycle.
  - Other requesters' resp_ready bits are ignored.
- Latency, no stalls: accept → srv_in_valid next cycle; server result → resp_valid next cycle.
- Range-reject path: accept → resp_valid 1 cycle later, with no server transaction.
- Only one request is outstanding. New requests wait; they are not dropped.
- A requester that deasserts req_valid before its grant simply loses its turn.
- srv_out_valid outside WAIT is ignored (srv_out_ready = 0 there).
- Reset during ISSUE/WAIT/RESP aborts the transaction. The stale server output is not consumed until the next WAIT; the integrator resets the server together with the scheduler.
- A requester whose req_valid stays high is re-granted only after all other pending requesters have been served (rr fairness).

Optional Feature:
FIBL_SCHED_CACHE_EN:
- With the macro defined:
  - One-entry cache {valid, arg, result}, written on every server result and cleared on reset.
  - In IDLE, a granted legal arg equal to the cached arg goes directly to RESP with the cached result and no server transaction. Response latency is 1 cycle.
  - Adds output cache_hit (1 bit), pulsed on the grant cycle of a hit.
- Without the macro: no cache logic, no cache_hit port; every legal request uses the server.

Test Plan:
Bench uses a behavioural fibl stub (fib(0)=0, fib(1)=1) with programmable 0–7-cycle latency and random in_ready stalls.
- Reset then idle: all outputs 0, busy = 0 for 20 cycles with no requests.
- Requester 2 arg = 10 → one srv transaction with srv_in0 = 10 → resp_valid = 4'b0100, resp_data = 55, resp_err = 0.
- All 4 requesters hold req_valid with args 1, 2, 3, 24 → grants in order 0, 1, 2, 3 → responses 1, 1, 2, 46368, each routed to its owner.
- Requester 1 arg = 25 → resp_err = 1, resp_data = 0, one cycle after accept; srv_in_valid never asserts.
- Assert rst during WAIT of arg 20 → outputs 0 immediately; after release, requester 0 arg 5 → resp_data = 5.
- FIBL_SCHED_CACHE_EN: arg 12 twice from requester 3 → second returns 144 with cache_hit = 1 and no srv handshake; without the macro → two srv handshakes.
